// File: rtl/control_sequencer_if.sv
// Instruction-memory req/ack handshake between control_sequencer and its fetch port.
// The sequencer uses the master modport; the memory side uses the slave modport.
interface control_sequencer_if #(
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (output imem_req, input imem_ack, input imem_data);
    modport slave  (input imem_req, output imem_ack, output imem_data);
endinterface

// File: rtl/control_sequencer.sv
// Fetch/decode/execute controller: fetches over the imem handshake, drives the registered control word and PC.
// Optional CU_SINGLE_STEP_EN adds a step input gating each fetch request.
module control_sequencer #(
    parameter int PC_W    = 6,
    parameter int INSTR_W = 16
) (
    input  logic                clk_main,
    input  logic                reset,
`ifdef CU_SINGLE_STEP_EN
    input  logic                step,
`endif
    control_sequencer_if.master imem,
    input  logic                Z,
    output logic [PC_W-1:0]     PC,
    output logic [3:0]          DR,
    output logic [3:0]          SA,
    output logic [3:0]          SB,
    output logic [3:0]          FS,
    output logic                MB,
    output logic                MM,
    output logic                MD,
    output logic                RW,
    output logic [INSTR_W-1:0]  const_out,
    output logic                mem_we,
    output logic                halted
);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} stateT;

    localparam logic [3:0] OP_BZ   = 4'b1011;
    localparam logic [3:0] OP_BNZ  = 4'b1100;
    localparam logic [3:0] OP_JMP  = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    stateT              state;
    logic [INSTR_W-1:0] ir;

    logic [3:0] opField, drField, saField, sbField;
    assign opField = ir[15:12];
    assign drField = ir[11:8];
    assign saField = ir[7:4];
    assign sbField = ir[3:0];

    logic [3:0]         decFS;
    logic               decMB, decMM, decMD, decRW, decWe;
    logic [INSTR_W-1:0] decConst;

    always_comb begin
        decFS    = '0;
        decMB    = 1'b0;
        decMM    = 1'b1;
        decMD    = 1'b0;
        decRW    = 1'b0;
        decWe    = 1'b0;
        decConst = '0;
        if (!opField[3]) begin
            decFS = {1'b0, opField[2:0]};
            decRW = 1'b1;
        end else begin
            case (opField[2:0])
                3'b000: begin
                    decFS    = 4'b0010;
                    decMB    = 1'b1;
                    decConst = INSTR_W'(sbField);
                    decRW    = 1'b1;
                end
                3'b001: begin
                    decMM = 1'b0;
                    decMD = 1'b1;
                    decRW = 1'b1;
                end
                3'b010: begin
                    decMM = 1'b0;
                    decWe = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Signed cast sign-extends the 8-bit offset before truncation to PC_W.
    logic signed [7:0] brOff;
    logic [PC_W-1:0]   pcInc, brTarget, nextPc;
    assign brOff    = {drField, sbField};
    assign pcInc    = PC + PC_W'(1);
    assign brTarget = pcInc + PC_W'(brOff);

    always_comb begin
        nextPc = pcInc;
        case (opField)
            OP_BZ:   if (Z)  nextPc = brTarget;
            OP_BNZ:  if (!Z) nextPc = brTarget;
            OP_JMP:  nextPc = PC_W'({saField[1:0], sbField});
            default: ;
        endcase
    end

    logic ackTaken, reqOnEntry, reqHold;
`ifdef CU_SINGLE_STEP_EN
    assign ackTaken   = imem.imem_ack && imem.imem_req;
    assign reqOnEntry = 1'b0;
    assign reqHold    = imem.imem_req || step;
`else
    assign ackTaken   = imem.imem_ack;
    assign reqOnEntry = 1'b1;
    assign reqHold    = 1'b1;
`endif

    always_ff @(posedge clk_main) begin
        if (!reset) begin
            state         <= FETCH;
            PC            <= '0;
            ir            <= '0;
            DR            <= '0;
            SA            <= '0;
            SB            <= '0;
            FS            <= '0;
            MB            <= 1'b0;
            MM            <= 1'b0;
            MD            <= 1'b0;
            RW            <= 1'b0;
            const_out     <= '0;
            mem_we        <= 1'b0;
            halted        <= 1'b0;
            imem.imem_req <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (ackTaken) begin
                        ir            <= imem.imem_data;
                        imem.imem_req <= 1'b0;
                        state         <= DECODE;
                    end else begin
                        imem.imem_req <= reqHold;
                    end
                end
                DECODE: begin
                    DR        <= drField;
                    SA        <= saField;
                    SB        <= sbField;
                    FS        <= decFS;
                    MB        <= decMB;
                    MM        <= decMM;
                    MD        <= decMD;
                    const_out <= decConst;
                    RW        <= decRW;
                    mem_we    <= decWe;
                    state     <= EXEC;
                end
                EXEC: begin
                    RW     <= 1'b0;
                    mem_we <= 1'b0;
                    if (opField == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        PC            <= nextPc;
                        imem.imem_req <= reqOnEntry;
                        state         <= FETCH;
                    end
                end
                HALT: ;
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random instruction streams
// checked against an instruction-level model of PC flow and control-word decode.
module tb_control_sequencer;

    logic        clk_main = 1'b0;
    logic        reset    = 1'b0;
    logic        step     = 1'b0;
    logic        Z        = 1'b0;
    logic [5:0]  PC;
    logic [3:0]  DR, SA, SB, FS;
    logic        MB, MM, MD, RW, mem_we, halted;
    logic [15:0] const_out;

    int vectors     = 0;
    int miscompares = 0;
    logic [5:0] mPc = '0;

    control_sequencer_if #(.INSTR_W(16)) bus ();

    control_sequencer #(.PC_W(6), .INSTR_W(16)) dut (
        .clk_main  (clk_main),
        .reset     (reset),
`ifdef CU_SINGLE_STEP_EN
        .step      (step),
`endif
        .imem      (bus),
        .Z         (Z),
        .PC        (PC),
        .DR        (DR),
        .SA        (SA),
        .SB        (SB),
        .FS        (FS),
        .MB        (MB),
        .MM        (MM),
        .MD        (MD),
        .RW        (RW),
        .const_out (const_out),
        .mem_we    (mem_we),
        .halted    (halted)
    );

    always #5 clk_main = ~clk_main;

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    // One full instruction: wait for req, stall lat cycles, ack, then check DECODE, EXEC and the next FETCH.
    task automatic runInstr(input logic [15:0] instr, input logic zv, input int lat);
        int op, off, nxt, expFS;
        logic [7:0] expCw, gotCw;
        op = int'(instr[15:12]);

        for (int i = 0; i < 20 && bus.imem_req !== 1'b1; i++) begin
            step = 1'b1;
            tick();
        end
        step = 1'b0;
        vectors++;
        if (bus.imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL req_wait: imem_req=%b want 1", bus.imem_req);
        end

        bus.imem_ack = 1'b0;
        for (int i = 0; i < lat; i++) begin
            tick();
            vectors++;
            if ({bus.imem_req, PC, RW, mem_we} !== {1'b1, mPc, 2'b00}) begin
                miscompares++;
                $display("FAIL stall: req/PC/RW/we=%b/%0d/%b/%b want 1/%0d/0/0",
                         bus.imem_req, PC, RW, mem_we, mPc);
            end
        end

        bus.imem_ack  = 1'b1;
        bus.imem_data = instr;
        tick();
        bus.imem_ack  = 1'($urandom_range(0, 1));
        bus.imem_data = 16'($urandom);
        Z = ~zv;
        vectors++;
        if ({bus.imem_req, RW, mem_we, halted} !== 4'b0000) begin
            miscompares++;
            $display("FAIL decode_cycle: req/RW/we/halted=%b%b%b%b want 0000",
                     bus.imem_req, RW, mem_we, halted);
        end

        tick();
        Z = zv;
        bus.imem_ack = 1'($urandom_range(0, 1));
        expFS = (op < 8) ? op : ((op == 8) ? 2 : 0);
        expCw = {4'(expFS), op == 8, op == 9, op <= 9, op == 10};
        gotCw = {FS, MB, MD, RW, mem_we};
        vectors++;
        if (gotCw !== expCw) begin
            miscompares++;
            $display("FAIL exec_ctrl instr=%h: FS,MB,MD,RW,we=%b want %b", instr, gotCw, expCw);
        end
        if (op <= 9) begin
            vectors++;
            if (DR !== instr[11:8]) begin
                miscompares++;
                $display("FAIL exec_DR instr=%h: DR=%h want %h", instr, DR, instr[11:8]);
            end
        end
        if (op <= 12 && op != 8) begin
            vectors++;
            if (SA !== instr[7:4]) begin
                miscompares++;
                $display("FAIL exec_SA instr=%h: SA=%h want %h", instr, SA, instr[7:4]);
            end
        end
        if (op < 8 || op == 10) begin
            vectors++;
            if (SB !== instr[3:0]) begin
                miscompares++;
                $display("FAIL exec_SB instr=%h: SB=%h want %h", instr, SB, instr[3:0]);
            end
        end
        if (op == 8) begin
            vectors++;
            if (const_out !== {12'b0, instr[3:0]}) begin
                miscompares++;
                $display("FAIL exec_const instr=%h: const_out=%h want %h", instr, const_out, instr[3:0]);
            end
        end
        if (op == 9 || op == 10) begin
            vectors++;
            if (MM !== 1'b0) begin
                miscompares++;
                $display("FAIL exec_MM instr=%h: MM=%b want 0", instr, MM);
            end
        end

        off = int'({instr[11:8], instr[3:0]});
        if (off >= 128) off -= 256;
        case (op)
            11:      nxt = zv  ? (int'(mPc) + 1 + off) & 63 : (int'(mPc) + 1) & 63;
            12:      nxt = !zv ? (int'(mPc) + 1 + off) & 63 : (int'(mPc) + 1) & 63;
            13:      nxt = int'(instr[5:4]) * 16 + int'(instr[3:0]);
            default: nxt = (int'(mPc) + 1) & 63;
        endcase

        tick();
        bus.imem_ack = 1'b0;
        if (op == 15) begin
            vectors++;
            if ({halted, bus.imem_req, RW, mem_we} !== 4'b1000) begin
                miscompares++;
                $display("FAIL halt_entry: halted/req/RW/we=%b%b%b%b want 1000",
                         halted, bus.imem_req, RW, mem_we);
            end
        end else begin
            mPc = 6'(nxt);
            vectors++;
            if ({PC, RW, mem_we, halted} !== {mPc, 3'b000}) begin
                miscompares++;
                $display("FAIL next_pc instr=%h Z=%b: PC=%0d RW/we/halted=%b%b%b want PC=%0d 000",
                         instr, zv, PC, RW, mem_we, halted, mPc);
            end
`ifndef CU_SINGLE_STEP_EN
            vectors++;
            if (bus.imem_req !== 1'b1) begin
                miscompares++;
                $display("FAIL fetch_first_req: imem_req=%b want 1", bus.imem_req);
            end
`endif
        end
    endtask

    task automatic checkAfterReleaseReq();
`ifdef CU_SINGLE_STEP_EN
        vectors++;
        if (bus.imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL release_req_step: imem_req=%b want 0", bus.imem_req);
        end
`else
        vectors++;
        if (bus.imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL release_req: imem_req=%b want 1", bus.imem_req);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.imem_ack  = 1'b0;
        bus.imem_data = '0;
        tick();
        tick();
        vectors++;
        if ({PC, DR, SA, SB, FS, MB, MM, MD, RW, const_out, mem_we, halted, bus.imem_req} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: PC=%0d DR=%h SA=%h SB=%h FS=%h MB%b MM%b MD%b RW%b c=%h we%b h%b req%b want all 0",
                     PC, DR, SA, SB, FS, MB, MM, MD, RW, const_out, mem_we, halted, bus.imem_req);
        end
        reset = 1'b1;
        tick();
        checkAfterReleaseReq();
        mPc = '0;
    endtask

    task automatic test_alu();
        runInstr(16'h2312, 1'b0, 0);
        vectors++;
        if (PC !== 6'd1) begin
            miscompares++;
            $display("FAIL alu_pc: PC=%0d want 1", PC);
        end
    endtask

    task automatic test_ack_stall();
        runInstr(16'hE000, 1'b1, 5);
    endtask

    task automatic test_branch();
        runInstr(16'hD005, 1'b0, 0);
        runInstr(16'hB0F2, 1'b1, 0);
        vectors++;
        if (PC !== 6'd8) begin
            miscompares++;
            $display("FAIL bz_taken: PC=%0d want 8", PC);
        end
        runInstr(16'hD005, 1'b0, 1);
        runInstr(16'hB0F2, 1'b0, 0);
        vectors++;
        if (PC !== 6'd6) begin
            miscompares++;
            $display("FAIL bz_not_taken: PC=%0d want 6", PC);
        end
        runInstr(16'hD000, 1'b1, 0);
        runInstr(16'hCF0F, 1'b0, 2);
        vectors++;
        if (PC !== 6'd0) begin
            miscompares++;
            $display("FAIL bnz_minus1: PC=%0d want 0", PC);
        end
    endtask

    task automatic test_jmp_wrap();
        runInstr(16'hD03F, 1'b0, 0);
        vectors++;
        if (PC !== 6'd63) begin
            miscompares++;
            $display("FAIL jmp_3f: PC=%0d want 63", PC);
        end
        runInstr(16'hE000, 1'b0, 0);
        vectors++;
        if (PC !== 6'd0) begin
            miscompares++;
            $display("FAIL wrap: PC=%0d want 0", PC);
        end
        runInstr(16'hA012, 1'b0, 0);
        runInstr(16'h9345, 1'b1, 1);
        runInstr(16'h8A07, 1'b0, 0);
    endtask

    task automatic test_reset_midfetch();
        runInstr(16'h1234, 1'b0, 0);
        for (int i = 0; i < 20 && bus.imem_req !== 1'b1; i++) begin
            step = 1'b1;
            tick();
        end
        step = 1'b0;
        reset = 1'b0;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 16'h0FFF;
        tick();
        vectors++;
        if ({PC, bus.imem_req, RW, halted} !== '0) begin
            miscompares++;
            $display("FAIL midfetch_reset: PC=%0d req/RW/halted=%b%b%b want 0 000",
                     PC, bus.imem_req, RW, halted);
        end
        tick();
        bus.imem_ack = 1'b0;
        reset = 1'b1;
        tick();
        checkAfterReleaseReq();
        mPc = '0;
        runInstr(16'h0765, 1'b1, 0);
    endtask

    task automatic test_random();
        logic [15:0] instr;
        for (int n = 0; n < 60; n++) begin
            instr = 16'($urandom);
            instr[15:12] = 4'($urandom_range(0, 14));
            runInstr(instr, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

`ifdef CU_SINGLE_STEP_EN
    task automatic test_single_step();
        runInstr(16'hE000, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            bus.imem_ack = 1'($urandom_range(0, 1));
            tick();
            vectors++;
            if ({bus.imem_req, RW} !== 2'b00) begin
                miscompares++;
                $display("FAIL step_gate: req/RW=%b%b want 00", bus.imem_req, RW);
            end
        end
        bus.imem_ack = 1'b0;
    endtask
`endif

    task automatic test_halt();
        runInstr(16'hF000, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            bus.imem_ack  = 1'(i % 2);
            bus.imem_data = 16'h2312;
            step = 1'b1;
            tick();
            vectors++;
            if ({halted, bus.imem_req, RW, mem_we} !== 4'b1000) begin
                miscompares++;
                $display("FAIL halt_hold: halted/req/RW/we=%b%b%b%b want 1000",
                         halted, bus.imem_req, RW, mem_we);
            end
        end
        step = 1'b0;
        bus.imem_ack = 1'b0;
        reset = 1'b0;
        tick();
        vectors++;
        if ({halted, PC} !== '0) begin
            miscompares++;
            $display("FAIL halt_reset: halted=%b PC=%0d want 0 0", halted, PC);
        end
        reset = 1'b1;
        tick();
        checkAfterReleaseReq();
        mPc = '0;
        runInstr(16'h4ABC, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ack_stall();
        test_branch();
        test_jmp_wrap();
        test_reset_midfetch();
`ifdef CU_SINGLE_STEP_EN
        test_single_step();
`endif
        test_random();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
